// File: rtl/fpm_sched.sv
// rtl/fpm_sched.sv - round-robin scheduler sharing one FP multiplier core among N requesters
module fpm_sched #(
    parameter int N       = 4,
    parameter int ID_W    = 2,
    parameter int MUL_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      req_valid,
    output logic [N-1:0]      req_ready,
    input  logic [32*N-1:0]   req_a,
    input  logic [32*N-1:0]   req_b,
    output logic [31:0]       mul_a,
    output logic [31:0]       mul_b,
    input  logic [31:0]       mul_p,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_p,
    output logic [ID_W-1:0]   rsp_id,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
    logic [31:0]       op_a_q, op_a_d;
    logic [31:0]       op_b_q, op_b_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_p_q, rsp_p_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;

    logic [31:0]       a_arr [N];
    logic [31:0]       b_arr [N];
    logic [ID_W-1:0]   gnt;
    logic              gnt_found;

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign a_arr[i] = req_a[32*i +: 32];
        assign b_arr[i] = req_b[32*i +: 32];
    end

    // Scan from the highest offset down so the requester closest to rr_ptr wins.
    always_comb begin
        logic [ID_W-1:0] idx;
        idx       = '0;
        gnt       = '0;
        gnt_found = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = ID_W'((int'(rr_ptr_q) + k) % N);
            if (req_valid[idx]) begin
                gnt       = idx;
                gnt_found = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && gnt_found) begin
            req_ready[gnt] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_id_d    = gnt_id_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_p_d     = rsp_p_q;
        rsp_id_d    = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    op_a_d   = a_arr[gnt];
                    op_b_d   = b_arr[gnt];
                    gnt_id_d = gnt;
                    cnt_d    = 4'(MUL_LAT - 1);
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_p_d     = mul_p;
                    rsp_id_d    = gnt_id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                    rr_ptr_d    = (gnt_id_q == ID_W'(N - 1)) ? '0 : gnt_id_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gnt_id_q    <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_p_q     <= '0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_id_q    <= gnt_id_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_p_q     <= rsp_p_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    // Operands stay on the core between operations; the core's output is only sampled in WAIT.
    assign mul_a     = op_a_q;
    assign mul_b     = op_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_p     = rsp_p_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fpm_sched.sv
// tb/tb_fpm_sched.sv - directed self-checking bench for fpm_sched (MUL_LAT=1 and MUL_LAT=3 instances)
module tb_fpm_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   rv1, rr1, rv3, rr3;
    logic [127:0] ra1, rb1, ra3, rb3;
    logic [31:0]  ma1, mb1, mp1, ma3, mb3, mp3, rp1, rp3;
    logic         rsv1, rsr1, rsv3, rsr3, busy1, busy3;
    logic [1:0]   rid1, rid3;
    logic [31:0]  d1, d2;
    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    // Reference core: 1.0 * x = x plus the specific products used below.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F80_0000) return b;
        case ({a, b})
            {32'h4000_0000, 32'h4080_0000}: return 32'h4100_0000;
            {32'h4040_0000, 32'h3F00_0000}: return 32'h3FC0_0000;
            default:                        return a ^ b ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    assign mp1 = fmul(ma1, mb1);
    always @(posedge clk) begin
        d1 <= fmul(ma3, mb3);
        d2 <= d1;
    end
    assign mp3 = d2;

    fpm_sched #(.N(4), .ID_W(2), .MUL_LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv1), .req_ready(rr1), .req_a(ra1), .req_b(rb1),
        .mul_a(ma1), .mul_b(mb1), .mul_p(mp1), .rsp_valid(rsv1), .rsp_ready(rsr1),
        .rsp_p(rp1), .rsp_id(rid1), .busy(busy1)
    );

    fpm_sched #(.N(4), .ID_W(2), .MUL_LAT(3)) u3 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv3), .req_ready(rr3), .req_a(ra3), .req_b(rb3),
        .mul_a(ma3), .mul_b(mb3), .mul_p(mp3), .rsp_valid(rsv3), .rsp_ready(rsr3),
        .rsp_p(rp3), .rsp_id(rid3), .busy(busy3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        ra1[32*i +: 32] = a;
        rb1[32*i +: 32] = b;
        rv1[i]          = 1'b1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, {28'b0, rr1}, 32'h0);
        chk({tag, "_rsp_valid"}, {31'b0, rsv1}, 32'h0);
        chk({tag, "_rsp_p"}, rp1, 32'h0);
        chk({tag, "_rsp_id"}, {30'b0, rid1}, 32'h0);
        chk({tag, "_mul_a"}, ma1, 32'h0);
        chk({tag, "_mul_b"}, mb1, 32'h0);
        chk({tag, "_busy"}, {31'b0, busy1}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        rv1 = '0; rv3 = '0; ra1 = '0; rb1 = '0; ra3 = '0; rb3 = '0;
        rsr1 = 1'b0; rsr3 = 1'b0;
        tick();
        tick();
        chk_reset("por");
        chk("por_u3_valid", {31'b0, rsv3}, 32'h0);
        chk("por_u3_busy", {31'b0, busy3}, 32'h0);

        // Single op: requester 2, 2.0 * 4.0
        rst_n = 1'b1;
        tick();
        set_op(2, 32'h4000_0000, 32'h4080_0000);
        #1;
        chk("t1_ready", {28'b0, rr1}, 32'h4);
        tick();
        rv1[2] = 1'b0;
        #1;
        chk("t1_ready_wait", {28'b0, rr1}, 32'h0);
        chk("t1_busy", {31'b0, busy1}, 32'h1);
        chk("t1_mul_a", ma1, 32'h4000_0000);
        chk("t1_mul_b", mb1, 32'h4080_0000);
        chk("t1_no_rsp_yet", {31'b0, rsv1}, 32'h0);
        tick();
        chk("t1_rsp_valid", {31'b0, rsv1}, 32'h1);
        chk("t1_rsp_p", rp1, 32'h4100_0000);
        chk("t1_rsp_id", {30'b0, rid1}, 32'h2);
        rsr1 = 1'b1;
        tick();
        chk("t1_rsp_done", {31'b0, rsv1}, 32'h0);
        chk("t1_idle", {31'b0, busy1}, 32'h0);
        rsr1 = 1'b0;

        // All four valid from reset: grants 0,1,2,3 on a 3-cycle cadence
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_op(i, 32'h4040_0000, 32'h3F00_0000);
        rsr1 = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t2_ready_%0d", k), {28'b0, rr1}, 32'(1 << k));
            tick();
            rv1[k] = 1'b0;
            chk($sformatf("t2_busy_%0d", k), {31'b0, busy1}, 32'h1);
            tick();
            chk($sformatf("t2_valid_%0d", k), {31'b0, rsv1}, 32'h1);
            chk($sformatf("t2_id_%0d", k), {30'b0, rid1}, 32'(k));
            chk($sformatf("t2_p_%0d", k), rp1, 32'h3FC0_0000);
            tick();
        end

        // Fairness after wrap, with 5 cycles of backpressure on requester 0's response
        set_op(0, 32'h3F80_0000, 32'h40A0_0000);
        set_op(3, 32'h3F80_0000, 32'hC000_0000);
        rsr1 = 1'b0;
        #1;
        chk("t3_ready_first", {28'b0, rr1}, 32'h1);
        tick();
        rv1[0] = 1'b0;
        tick();
        for (int b = 0; b < 5; b++) begin
            chk($sformatf("t4_valid_%0d", b), {31'b0, rsv1}, 32'h1);
            chk($sformatf("t4_p_%0d", b), rp1, 32'h40A0_0000);
            chk($sformatf("t4_id_%0d", b), {30'b0, rid1}, 32'h0);
            chk($sformatf("t4_ready_%0d", b), {28'b0, rr1}, 32'h0);
            tick();
        end
        rsr1 = 1'b1;
        #1;
        chk("t4_accept_valid", {31'b0, rsv1}, 32'h1);
        chk("t4_accept_ready", {28'b0, rr1}, 32'h0);
        tick();
        chk("t3_ready_second", {28'b0, rr1}, 32'h8);
        tick();
        rv1[3] = 1'b0;
        tick();
        chk("t3_id_second", {30'b0, rid1}, 32'h3);
        chk("t3_p_second", rp1, 32'hC000_0000);
        tick();

        // Serve requester 1 so rr_ptr=2, then reset while requester 2 is in WAIT
        set_op(1, 32'h3F80_0000, 32'h4040_0000);
        #1;
        chk("t5_ready_r1", {28'b0, rr1}, 32'h2);
        tick();
        rv1[1] = 1'b0;
        tick();
        chk("t5_p_r1", rp1, 32'h4040_0000);
        tick();
        rsr1 = 1'b0;
        set_op(2, 32'h3F80_0000, 32'h40E0_0000);
        #1;
        chk("t5_ready_r2", {28'b0, rr1}, 32'h4);
        tick();
        rv1[2] = 1'b0;
        chk("t5_busy_wait", {31'b0, busy1}, 32'h1);
        rst_n = 1'b0;
        tick();
        chk_reset("t5_rst");
        rst_n = 1'b1;
        for (int w = 0; w < 3; w++) begin
            tick();
            chk($sformatf("t5_no_rsp_%0d", w), {31'b0, rsv1}, 32'h0);
        end
        set_op(0, 32'h3F80_0000, 32'h4040_0000);
        set_op(2, 32'h3F80_0000, 32'h40E0_0000);
        #1;
        chk("t5_ready_after_rst", {28'b0, rr1}, 32'h1);
        tick();
        rv1 = '0;
        tick();
        chk("t5_id_after_rst", {30'b0, rid1}, 32'h0);
        rsr1 = 1'b1;
        tick();

        // MUL_LAT=3: operands held for 3 WAIT cycles, response in the 4th cycle after grant
        ra3[63:32] = 32'h3F80_0000;
        rb3[63:32] = 32'h4120_0000;
        rv3 = 4'b0010;
        rsr3 = 1'b1;
        #1;
        chk("t6_ready", {28'b0, rr3}, 32'h2);
        tick();
        rv3 = '0;
        for (int w = 0; w < 3; w++) begin
            chk($sformatf("t6_busy_%0d", w), {31'b0, busy3}, 32'h1);
            chk($sformatf("t6_mul_a_%0d", w), ma3, 32'h3F80_0000);
            chk($sformatf("t6_mul_b_%0d", w), mb3, 32'h4120_0000);
            chk($sformatf("t6_no_rsp_%0d", w), {31'b0, rsv3}, 32'h0);
            tick();
        end
        chk("t6_valid", {31'b0, rsv3}, 32'h1);
        chk("t6_p", rp3, 32'h4120_0000);
        chk("t6_id", {30'b0, rid3}, 32'h1);
        tick();
        chk("t6_done", {31'b0, rsv3}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
